// File: rtl/interleaver_pp_ctrl.sv
// interleaver_pp_ctrl: ping-pong bank sequencer writing natural order and reading column-permuted order
module interleaver_pp_ctrl #(
  parameter int NCBPS  = 192,
  parameter int ROWS   = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              wren_a,
  output logic              wren_b,
  output logic [ADDR_W-1:0] wraddress,
  output logic              rden_a,
  output logic              rden_b,
  output logic [ADDR_W-1:0] rdaddress,
  input  logic              q_a,
  input  logic              q_b,
  output logic              q,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              block_done
);
  localparam int COLS = NCBPS / ROWS;
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
  typedef enum logic [1:0] {R_IDLE, R_A, R_B, R_WAIT} rd_state_t;
  rd_state_t st, st_n;
  logic wr_bank, full_a, full_b, rd_nxt, rd_bank_q, last_q, valid_q;
  logic [ADDR_W-1:0] wr_cnt, rd_addr;
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic wr_acc, wr_last, rd_adv, xfer, done, rd_last, bank, avail, issue;
  assign xfer = valid_q && ready_in;
  assign done = xfer && last_q;
  assign block_done = done;
  // The bank being drained may be refilled on the very edge its last bit leaves.
  assign ready_out = !(wr_bank ? full_b : full_a) || (done && rd_bank_q == wr_bank);
  assign wr_acc = valid_in && ready_out;
  assign wr_last = wr_cnt == ADDR_W'(NCBPS - 1);
  assign wren_a = wr_acc && !wr_bank;
  assign wren_b = wr_acc && wr_bank;
  assign wraddress = wr_cnt;
  assign rd_adv = !valid_q || ready_in;
  assign rd_last = r == RW'(ROWS - 1) && c == CW'(COLS - 1);
  assign rdaddress = rd_addr;
  assign valid_out = valid_q;
  assign q = rd_bank_q ? q_b : q_a;
  always_comb begin
    bank = st == R_B ? 1'b1 : st == R_A ? 1'b0 : rd_nxt;
    avail = st == R_A || st == R_B || ((rd_nxt ? full_b : full_a) && (st == R_IDLE || done));
    issue = avail && rd_adv;
    st_n = issue ? (rd_last ? R_WAIT : (bank ? R_B : R_A)) : (st == R_WAIT && done) ? R_IDLE : st;
    rden_a = issue && !bank;
    rden_b = issue && bank;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= R_IDLE;
      wr_bank <= 1'b0;
      wr_cnt <= '0;
      full_a <= 1'b0;
      full_b <= 1'b0;
      rd_nxt <= 1'b0;
      rd_bank_q <= 1'b0;
      last_q <= 1'b0;
      valid_q <= 1'b0;
      rd_addr <= '0;
      r <= '0;
      c <= '0;
    end else begin
      st <= st_n;
      if (wr_acc) begin
        wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
        if (wr_last) wr_bank <= !wr_bank;
      end
      full_a <= (wr_acc && wr_last && !wr_bank) ? 1'b1 : (done && !rd_bank_q) ? 1'b0 : full_a;
      full_b <= (wr_acc && wr_last && wr_bank) ? 1'b1 : (done && rd_bank_q) ? 1'b0 : full_b;
      valid_q <= issue ? 1'b1 : xfer ? 1'b0 : valid_q;
      if (issue) begin
        rd_bank_q <= bank;
        last_q <= rd_last;
        if (rd_last) rd_nxt <= !bank;
        // Column-major walk by repeated addition: step a row, or restart at the next column.
        if (r == RW'(ROWS - 1)) begin
          r <= '0;
          c <= rd_last ? '0 : c + 1'b1;
          rd_addr <= rd_last ? '0 : ADDR_W'(c) + ADDR_W'(1);
        end else begin
          r <= r + 1'b1;
          rd_addr <= rd_addr + ADDR_W'(COLS);
        end
      end
    end
  end
endmodule

// File: tb/tb_interleaver_pp_ctrl.sv
// tb_interleaver_pp_ctrl: scoreboard bench with bank memories and a block-level permutation model
module tb_interleaver_pp_ctrl;
  localparam int N = 192, ROWS = 16, COLS = 12, AW = 8;
  logic clk = 0, reset = 1, valid_in = 0, ready_in = 0, din = 0;
  logic ready_out, wren_a, wren_b, rden_a, rden_b, q_a, q_b, q, valid_out, block_done;
  logic [AW-1:0] wraddress, rdaddress;
  logic mem_a [256];
  logic mem_b [256];
  int vecs = 0, errs = 0;
  int wcnt, wbank_m, pending, rk, rbank_m, ok_k, gaps;
  bit blk [N];
  bit exp_q [$];
  bit started, prev_stall, prev_q, acc, lastx;
  logic [AW-1:0] prev_addr;
  int sent, stalls;

  interleaver_pp_ctrl #(.NCBPS(N), .ROWS(ROWS), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
    .wren_a(wren_a), .wren_b(wren_b), .wraddress(wraddress),
    .rden_a(rden_a), .rden_b(rden_b), .rdaddress(rdaddress),
    .q_a(q_a), .q_b(q_b), .q(q), .valid_out(valid_out), .ready_in(ready_in),
    .block_done(block_done));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      q_a <= 1'b0;
      q_b <= 1'b1;
    end else begin
      if (wren_a) mem_a[wraddress] <= din;
      if (wren_b) mem_b[wraddress] <= din;
      if (rden_a) q_a <= mem_a[rdaddress];
      if (rden_b) q_b <= mem_b[rdaddress];
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int perm(input int k);
    return COLS * (k % ROWS) + k / ROWS;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      wcnt = 0; wbank_m = 0; pending = 0; rk = 0; rbank_m = 0; ok_k = 0; prev_stall = 0;
    end else begin
      acc = valid_in && ready_out;
      lastx = valid_out && ready_in && ok_k == N - 1;
      chk("ready_out", ready_out, int'(pending < 2 || lastx));
      chk("wren_a", wren_a, int'(acc && wbank_m == 0));
      chk("wren_b", wren_b, int'(acc && wbank_m == 1));
      if (acc) begin
        chk("wraddress", wraddress, wcnt);
        blk[wcnt] = din;
        wcnt++;
        if (wcnt == N) begin
          for (int k = 0; k < N; k++) exp_q.push_back(blk[perm(k)]);
          wcnt = 0; wbank_m ^= 1; pending++;
        end
      end
      if (rden_a || rden_b) begin
        chk("rd_bank", rden_b, rbank_m);
        chk("rdaddress", rdaddress, perm(rk));
        rk++;
        if (rk == N) begin rk = 0; rbank_m ^= 1; end
      end
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) chk("q_unexpected", 1, 0);
        else chk("q", q, exp_q.pop_front());
        chk("block_done", block_done, int'(ok_k == N - 1));
        if (ok_k == N - 1) begin ok_k = 0; pending--; end
        else ok_k++;
      end else chk("block_done_idle", block_done, 0);
      if (prev_stall) begin
        chk("hold_q", q, prev_q);
        chk("hold_valid", valid_out, 1);
        chk("hold_rdaddress", rdaddress, prev_addr);
      end
      if (valid_out && !ready_in) chk("stall_rden", rden_a | rden_b, 0);
      prev_stall = valid_out && !ready_in;
      prev_q = q;
      prev_addr = rdaddress;
      if (started && !valid_out && exp_q.size() > 0) gaps++;
      if (valid_out) started = 1;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1; valid_in = 0; ready_in = 0;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("rst_ready_out", ready_out, 1);
    chk("rst_wren", wren_a | wren_b, 0);
    chk("rst_rden", rden_a | rden_b, 0);
    chk("rst_wraddress", wraddress, 0);
    chk("rst_rdaddress", rdaddress, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_block_done", block_done, 0);
    chk("rst_q_from_a", q, 0);
    started = 0; gaps = 0;
  endtask

  function automatic logic rdy(input int rmode, input int i);
    return rmode == 0 ? 1'b1 : rmode == 1 ? 1'b0 : rmode == 2 ? i[0] == 0 : 1'($urandom_range(0, 1));
  endfunction

  task automatic send(input int n, input int maxc, input bit vrand, input int rmode, input bit pat,
                      output int s, output int st);
    s = 0; st = 0;
    for (int i = 0; i < maxc && s < n; i++) begin
      @(posedge clk); #1;
      valid_in = vrand ? $urandom_range(0, 3) != 0 : 1'b1;
      din = pat ? s[0] : 1'($urandom);
      ready_in = rdy(rmode, i);
      @(negedge clk);
      if (valid_in && ready_out) s++;
      else if (!ready_out) st++;
    end
  endtask

  task automatic idle(input int n, input int rmode);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      valid_in = 0;
      ready_in = rdy(rmode, i);
    end
    @(negedge clk);
  endtask

  initial begin
    do_reset();
    send(N, 400, 0, 0, 1, sent, stalls);
    chk("t1_sent", sent, N);
    @(posedge clk); #1;
    valid_in = 0;
    @(negedge clk);
    chk("t1_lat_rden_a", rden_a, 1);
    chk("t1_lat_rdaddress", rdaddress, 0);
    @(negedge clk);
    chk("t1_lat_valid_out", valid_out, 1);
    idle(300, 0);
    chk("t1_drained", exp_q.size(), 0);

    do_reset();
    send(3 * N, 700, 0, 0, 0, sent, stalls);
    chk("t2_sent", sent, 3 * N);
    chk("t2_ready_stalls", stalls, 0);
    idle(300, 0);
    chk("t2_output_gaps", gaps, 0);
    chk("t2_drained", exp_q.size(), 0);

    do_reset();
    send(400, 1000, 0, 1, 0, sent, stalls);
    chk("t3_accepted", sent, 2 * N);
    @(negedge clk);
    chk("t3_ready_out", ready_out, 0);
    chk("t3_valid_out", valid_out, 1);
    if (exp_q.size() > 0) chk("t3_q_bit0", q, exp_q[0]);
    else chk("t3_queue_present", 0, 1);
    idle(600, 0);
    chk("t3_drained", exp_q.size(), 0);

    do_reset();
    send(2 * N, 2000, 1, 2, 0, sent, stalls);
    chk("t4_sent", sent, 2 * N);
    idle(900, 2);
    chk("t4_drained", exp_q.size(), 0);

    do_reset();
    send(100, 200, 0, 0, 0, sent, stalls);
    do_reset();
    send(N, 400, 0, 0, 0, sent, stalls);
    chk("t5_sent", sent, N);
    idle(300, 0);
    chk("t5_drained", exp_q.size(), 0);

    do_reset();
    send(N, 300, 0, 0, 0, sent, stalls);
    idle(1, 0);
    send(400, 500, 0, 0, 0, sent, stalls);
    chk("t6_sent", sent, 400);
    chk("t6_ready_stalls", stalls, 0);
    idle(500, 0);
    chk("t6_drained", exp_q.size(), 0);

    do_reset();
    send(600, 3000, 1, 3, 0, sent, stalls);
    chk("t7_sent", sent, 600);
    idle(1500, 3);
    chk("t7_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
